vga_mem_scheduler: RTL and testbench
====================================

Name: vga_mem_scheduler

Overview:
- Schedules a single-port pixel memory shared by VGA scan-out and a host read/write port.
- Scan-out is driven by the VGA area tracker outputs (coords, visible, frame sync) and has absolute priority during the visible area.
- The host is served only in blanking cycles.
- Read returns are steered back to the correct requester via a tag pipeline.
- Manages double-buffer page flips, applied only on frame sync.

Parameters:
- P_CNT_WIDTH, 8, width of tracker coordinate inputs.
- P_H_BITS, 8, horizontal address bits taken from h coord (≤ P_CNT_WIDTH).
- P_V_BITS, 7, vertical address bits taken from v coord (≤ P_CNT_WIDTH).
- P_DATA_WIDTH, 8, pixel word width.
- P_RD_LATENCY, 2, memory read latency: cycles from registered o_mem_en to valid ia_mem_rdata (≥1).
- Derived localparam LP_ADDR_W = 1 + P_V_BITS + P_H_BITS.

Ports:
- i_clk  in  1  clock. One clock; reset is asynchronous and active-low.
- i_rst_n  in  1  async active-low reset.
- ia_h_coord  in  P_CNT_WIDTH  tracker horizontal coord.
- ia_v_coord  in  P_CNT_WIDTH  tracker vertical coord.
- i_visible  in  1  tracker visible flag.
- i_frame_sync  in  1  tracker end-of-frame pulse.
- o_pix_valid  out  1  oa_pix_data valid.
- oa_pix_data  out  P_DATA_WIDTH  fetched pixel.
- i_host_valid  in  1  host request valid.
- o_host_ready  out  1  host request accepted this cycle.
- i_host_we  in  1  1 = write, 0 = read.
- ia_host_addr  in  LP_ADDR_W  full address, MSB = page.
- ia_host_wdata  in  P_DATA_WIDTH  write data.
- o_host_rvalid  out  1  host read data valid.
- oa_host_rdata  out  P_DATA_WIDTH  host read data.
- i_flip_req  in  1  request page swap (pulse).
- o_flip_pending  out  1  flip armed, awaiting frame sync.
- o_disp_page  out  1  page being scanned out.
- o_mem_en  out  1  memory access strobe (registered).
- o_mem_we  out  1  memory write (registered).
- oa_mem_addr  out  LP_ADDR_W  memory address (registered).
- oa_mem_wdata  out  P_DATA_WIDTH  memory write data (registered).
- ia_mem_rdata  in  P_DATA_WIDTH  memory read data.

Behaviour:
- Reset (async assert, sync release): all outputs 0, including o_disp_page = 0 and o_flip_pending = 0. Tag pipeline cleared. Reads in flight at reset are dropped and produce no valid.
- Grant (combinational per cycle):
  - If i_visible = 1: display read of {o_disp_page, v_coord[P_V_BITS-1:0], h_coord[P_H_BITS-1:0]}. Upper coord bits are ignored.
  - Else if i_host_valid = 1: host access.
  - Else: idle.
- o_host_ready = ~i_visible (combinational). A host transfer occurs on i_host_valid & o_host_ready.
- Host must hold valid, we, addr and wdata stable until accepted. The block never drops an accepted request.
- Granted request is registered onto the o_mem_* outputs next cycle. Idle cycle → o_mem_en = 0, o_mem_we = 0; address and data hold previous values.
- Tag pipeline: P_RD_LATENCY-deep shift of {disp, host} bits, loaded alongside the registered read request. Writes load tag 00.
- When a tag exits, ia_mem_rdata is registered into oa_pix_data / oa_host_rdata, with o_pix_valid / o_host_rvalid pulsed for 1 cycle. Data outputs hold their last value when the valid is low.
- Latency: coords at cycle t → o_pix_valid at t + P_RD_LATENCY + 2. Host read accepted at t → o_host_rvalid at t + P_RD_LATENCY + 2. Write lands in memory at t+1.
- Back-to-back accesses every cycle are supported; there is no bubble between display and host grants.
- Page flip:
  - i_flip_req sets flip_pending.
  - i_frame_sync with flip_pending = 1 toggles o_disp_page and clears pending, visible the next cycle.
  - i_flip_req with pending already 1 is ignored (no double toggle).
  - i_flip_req in the same cycle as i_frame_sync with pending = 0 arms for the following frame sync, not the current one.
- Host writes to the displayed page are permitted; tearing avoidance is the host's responsibility.
- Host is starved for the whole visible region by design. No timeout.

Test Plan:
- Reset, then hold i_visible = 1 with h = 5, v = 3, page 0. Expect o_mem_addr = {0,3,5}, o_mem_en = 1 next cycle, o_pix_valid 4 cycles after coords (latency 2), and oa_pix_data equal to the memory model content.
- i_visible = 1 and i_host_valid = 1 (write 0xA5 to 0x1_0010) for 10 cycles. Expect o_host_ready = 0 throughout. On i_visible → 0, ready = 1 the same cycle, and the write is issued next cycle with o_mem_we = 1 and addr 0x1_0010.
- Blanking: host read 0x00020 followed by a read of the next coord, back-to-back. Expect two o_host_rvalid pulses, each 4 cycles after acceptance, with the correct data and no o_pix_valid.
- Alternate a visible read cycle, a host read, then a visible read. Expect tags to steer data correctly: pix, host, pix valids in order with no cross-delivery.
- i_flip_req pulse, then i_frame_sync 20 cycles later. Expect o_flip_pending = 1 until the sync and o_disp_page 0 → 1 the cycle after. Also check flip_req coincident with frame_sync and pending = 0: no toggle until the next sync.
- Assert i_rst_n = 0 mid-stream with 2 reads in flight. Expect all valids 0 immediately and after release, page = 0, pending = 0.

Source files
------------

// File: rtl/vga_mem_scheduler.sv
// Single-port pixel memory scheduler: VGA scan-out owns the memory during the
// visible area, the host port is served in blanking, and read data is steered back by tag.
module vga_mem_scheduler #(
  parameter  int P_CNT_WIDTH  = 8,
  parameter  int P_H_BITS     = 8,
  parameter  int P_V_BITS     = 7,
  parameter  int P_DATA_WIDTH = 8,
  parameter  int P_RD_LATENCY = 2,
  localparam int LP_ADDR_W    = 1 + P_V_BITS + P_H_BITS
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P_CNT_WIDTH-1:0]  ia_h_coord,
  input  logic [P_CNT_WIDTH-1:0]  ia_v_coord,
  input  logic                    i_visible,
  input  logic                    i_frame_sync,
  output logic                    o_pix_valid,
  output logic [P_DATA_WIDTH-1:0] oa_pix_data,
  input  logic                    i_host_valid,
  output logic                    o_host_ready,
  input  logic                    i_host_we,
  input  logic [LP_ADDR_W-1:0]    ia_host_addr,
  input  logic [P_DATA_WIDTH-1:0] ia_host_wdata,
  output logic                    o_host_rvalid,
  output logic [P_DATA_WIDTH-1:0] oa_host_rdata,
  input  logic                    i_flip_req,
  output logic                    o_flip_pending,
  output logic                    o_disp_page,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [LP_ADDR_W-1:0]    oa_mem_addr,
  output logic [P_DATA_WIDTH-1:0] oa_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0] ia_mem_rdata
);

  typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_HOST} grant_e;
  typedef struct packed {
    logic disp;
    logic host;
  } tag_t;

  grant_e               grant;
  logic [LP_ADDR_W-1:0] disp_addr;
  tag_t                 req_tag;
  tag_t                 tag_pipe [P_RD_LATENCY];

  // Coordinate bits above the address slice are intentionally ignored.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{ia_h_coord, ia_v_coord};

  assign disp_addr    = {o_disp_page, ia_v_coord[P_V_BITS-1:0], ia_h_coord[P_H_BITS-1:0]};
  assign o_host_ready = ~i_visible;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    grant = GNT_IDLE;
    if (i_visible)         grant = GNT_DISP;
    else if (i_host_valid) grant = GNT_HOST;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_en     <= 1'b0;
      o_mem_we     <= 1'b0;
      oa_mem_addr  <= '0;
      oa_mem_wdata <= '0;
      req_tag      <= '0;
    end else begin
      o_mem_en <= (grant != GNT_IDLE);
      o_mem_we <= (grant == GNT_HOST) && i_host_we;
      req_tag  <= '{disp: (grant == GNT_DISP), host: (grant == GNT_HOST) && !i_host_we};
      case (grant)
        GNT_DISP: oa_mem_addr <= disp_addr;
        GNT_HOST: begin
          oa_mem_addr  <= ia_host_addr;
          oa_mem_wdata <= ia_host_wdata;
        end
        default: ;
      endcase
    end
  end

  // req_tag travels with o_mem_*; the shift below then covers the memory latency,
  // so the last stage lines up with valid read data.
  // NOTE: the tag shift is explicitly reset so reads in flight at reset never return a valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < P_RD_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= req_tag;
      for (int i = 1; i < P_RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_valid   <= 1'b0;
      oa_pix_data   <= '0;
      o_host_rvalid <= 1'b0;
      oa_host_rdata <= '0;
    end else begin
      o_pix_valid   <= tag_pipe[P_RD_LATENCY-1].disp;
      o_host_rvalid <= tag_pipe[P_RD_LATENCY-1].host;
      if (tag_pipe[P_RD_LATENCY-1].disp) oa_pix_data   <= ia_mem_rdata;
      if (tag_pipe[P_RD_LATENCY-1].host) oa_host_rdata <= ia_mem_rdata;
    end
  end

  // A flip request coincident with the sync only arms; it never swaps on that same sync.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_disp_page    <= 1'b0;
      o_flip_pending <= 1'b0;
    end else if (i_frame_sync && o_flip_pending) begin
      o_disp_page    <= ~o_disp_page;
      o_flip_pending <= 1'b0;
    end else if (i_flip_req) begin
      o_flip_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_mem_scheduler.sv
// Bench for vga_mem_scheduler: a grant-level model predicts memory requests and
// returns per cycle, and directed vectors pin hand-computed values.
module tb_vga_mem_scheduler;
  localparam int CW = 8, HB = 8, VB = 7, DW = 8, L = 2;
  localparam int AW = 1 + VB + HB;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic [CW-1:0] h, v;
  logic          vis, fsync, pix_v, hvalid, hready, hwe, hrvalid, flip, pend, page;
  logic          men, mwe;
  logic [AW-1:0] haddr, maddr;
  logic [DW-1:0] pix_d, hwdata, hrdata, mwdata, mrdata;

  always #5 clk = ~clk;

  vga_mem_scheduler dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .ia_h_coord(h), .ia_v_coord(v),
    .i_visible(vis), .i_frame_sync(fsync), .o_pix_valid(pix_v), .oa_pix_data(pix_d),
    .i_host_valid(hvalid), .o_host_ready(hready), .i_host_we(hwe), .ia_host_addr(haddr),
    .ia_host_wdata(hwdata), .o_host_rvalid(hrvalid), .oa_host_rdata(hrdata),
    .i_flip_req(flip), .o_flip_pending(pend), .o_disp_page(page),
    .o_mem_en(men), .o_mem_we(mwe), .oa_mem_addr(maddr), .oa_mem_wdata(mwdata),
    .ia_mem_rdata(mrdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Physical memory with a fixed read latency, driven only by the DUT's o_mem_*.
  logic [DW-1:0] phys_mem [1<<AW];
  logic [DW-1:0] rd_pipe  [L];
  always @(posedge clk) begin
    if (men && mwe) phys_mem[maddr] <= mwdata;
    if (men && !mwe) rd_pipe[0] <= phys_mem[maddr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mrdata = rd_pipe[L-1];

  // Model: per cycle, decide who owns the memory and schedule what must appear
  // on o_mem_* one cycle later and on the return ports L+2 cycles later.
  logic [DW-1:0] model_mem [1<<AW];
  bit            e_men [16], e_mwe [16], e_pv [16], e_hv [16], e_page [16], e_pend [16];
  logic [AW-1:0] e_maddr [16];
  logic [DW-1:0] e_mwd [16], e_pd [16], e_hd [16];
  bit            m_page, m_pend;
  logic [AW-1:0] m_addr, a;
  logic [DW-1:0] m_wd;
  int            cyc = 0;
  int            s1, sr, sc;

  always @(posedge clk) begin
    s1 = (cyc + 1) % 16;
    sr = (cyc + L + 2) % 16;
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) begin
        e_men[i] = 0; e_mwe[i] = 0; e_pv[i] = 0; e_hv[i] = 0; e_page[i] = 0; e_pend[i] = 0;
        e_maddr[i] = '0; e_mwd[i] = '0; e_pd[i] = '0; e_hd[i] = '0;
      end
      m_page = 0; m_pend = 0; m_addr = '0; m_wd = '0;
    end else begin
      e_men[s1] = 0; e_mwe[s1] = 0; e_pv[sr] = 0; e_hv[sr] = 0;
      if (vis) begin
        a = {m_page, v[VB-1:0], h[HB-1:0]};
        m_addr = a; e_men[s1] = 1;
        e_pv[sr] = 1; e_pd[sr] = model_mem[a];
      end else if (hvalid) begin
        m_addr = haddr; m_wd = hwdata; e_men[s1] = 1;
        if (hwe) begin
          e_mwe[s1] = 1; model_mem[haddr] = hwdata;
        end else begin
          e_hv[sr] = 1; e_hd[sr] = model_mem[haddr];
        end
      end
      e_maddr[s1] = m_addr; e_mwd[s1] = m_wd;
      if (fsync && m_pend) begin
        m_page = !m_page; m_pend = 0;
      end else if (flip) begin
        m_pend = 1;
      end
      e_page[s1] = m_page; e_pend[s1] = m_pend;
    end
    cyc++;
  end

  always @(negedge clk) begin
    sc = cyc % 16;
    if (!i_rst_n) begin
      check("rst_pix_valid", pix_v, 0);
      check("rst_host_rvalid", hrvalid, 0);
      check("rst_mem_en", men, 0);
      check("rst_page", page, 0);
      check("rst_pending", pend, 0);
    end else begin
      check("host_ready", hready, !vis);
      check("mem_en", men, e_men[sc]);
      check("mem_we", mwe, e_mwe[sc]);
      check("mem_addr", maddr, e_maddr[sc]);
      if (e_mwe[sc]) check("mem_wdata", mwdata, e_mwd[sc]);
      check("pix_valid", pix_v, e_pv[sc]);
      if (e_pv[sc]) check("pix_data", pix_d, e_pd[sc]);
      check("host_rvalid", hrvalid, e_hv[sc]);
      if (e_hv[sc]) check("host_rdata", hrdata, e_hd[sc]);
      check("disp_page", page, e_page[sc]);
      check("flip_pending", pend, e_pend[sc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vis = 0; hvalid = 0; hwe = 0; fsync = 0; flip = 0;
  endtask

  task automatic vis_at(input logic [CW-1:0] hh, input logic [CW-1:0] vv);
    vis = 1; h = hh; v = vv;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      phys_mem[i]  = init_val(AW'(i));
      model_mem[i] = init_val(AW'(i));
    end
    for (int i = 0; i < L; i++) rd_pipe[i] = '0;
    i_rst_n = 0; h = '0; v = '0; haddr = '0; hwdata = '0;
    idle();
    repeat (3) step();
    i_rst_n = 1;
    check("reset_page", page, 0);
    check("reset_mem_en", men, 0);

    // Display read of h=5, v=3 on page 0; upper v bit must be dropped.
    vis_at(8'h05, 8'h83);
    step();
    idle();
    check("t1_mem_en", men, 1);
    check("t1_mem_addr", maddr, 16'h0305);
    repeat (3) step();
    check("t1_pix_valid", pix_v, 1);
    check("t1_pix_data", pix_d, 8'h5C);
    step();

    // Host write starved by 10 visible cycles, then issued on the first blank cycle.
    hvalid = 1; hwe = 1; haddr = 16'h8010; hwdata = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      vis_at(8'(i), 8'h01);
      #1 check("t2_ready_low", hready, 0);
      step();
    end
    vis = 0;
    #1 check("t2_ready_high", hready, 1);
    step();
    hvalid = 0; hwe = 0;
    check("t2_mem_we", mwe, 1);
    check("t2_mem_addr", maddr, 16'h8010);
    check("t2_mem_wdata", mwdata, 8'hA5);
    repeat (6) step();

    // Back-to-back host reads in blanking.
    hvalid = 1; haddr = 16'h0020;
    step();
    haddr = 16'h0021;
    step();
    hvalid = 0;
    repeat (2) step();
    check("t3_rvalid0", hrvalid, 1);
    check("t3_rdata0", hrdata, 8'h7A);
    step();
    check("t3_rvalid1", hrvalid, 1);
    check("t3_rdata1", hrdata, 8'h7B);
    step();
    check("t3_rvalid_end", hrvalid, 0);

    // Read back the earlier write.
    hvalid = 1; haddr = 16'h8010;
    step();
    hvalid = 0;
    repeat (3) step();
    check("t3_wr_readback", hrdata, 8'hA5);
    repeat (2) step();

    // Interleaved pix / host / pix reads.
    vis_at(8'h07, 8'h02);
    step();
    vis = 0; hvalid = 1; haddr = 16'h0020;
    step();
    hvalid = 0; vis_at(8'h08, 8'h02);
    step();
    idle();
    step();
    check("t4_pix0", pix_d, 8'h5F);
    step();
    check("t4_host_only", pix_v, 0);
    check("t4_host", hrdata, 8'h7A);
    step();
    check("t4_pix1", pix_d, 8'h50);
    repeat (3) step();

    // Page flip armed, applied on the sync 20 cycles later.
    flip = 1;
    step();
    flip = 0;
    check("t5_pending", pend, 1);
    repeat (19) step();
    check("t5_page_before", page, 0);
    fsync = 1;
    step();
    fsync = 0;
    check("t5_page_after", page, 1);
    check("t5_pending_clr", pend, 0);
    vis_at(8'h05, 8'h03);
    step();
    idle();
    check("t5_page1_addr", maddr, 16'h8305);
    repeat (4) step();

    // Flip coincident with sync while idle arms for the next sync only.
    flip = 1; fsync = 1;
    step();
    idle();
    check("t5_coinc_page", page, 1);
    check("t5_coinc_pend", pend, 1);
    repeat (3) step();
    fsync = 1;
    step();
    fsync = 0;
    check("t5_second_sync", page, 0);

    // Repeated flip while armed must still toggle once.
    flip = 1;
    step();
    step();
    flip = 0; fsync = 1;
    step();
    fsync = 0;
    check("t5_single_toggle", page, 1);
    step();

    // Reset with two reads in flight.
    vis_at(8'h01, 8'h01);
    step();
    vis_at(8'h02, 8'h01);
    step();
    idle();
    #1 i_rst_n = 0;
    #1;
    check("t6_pix_valid", pix_v, 0);
    check("t6_page", page, 0);
    check("t6_pending", pend, 0);
    repeat (2) step();
    i_rst_n = 1;
    repeat (6) step();
    check("t6_page_after", page, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
